jk_reg_bank: RTL and testbench
==============================

Name: jk_reg_bank

Overview:
- Parametrised, clocked successor to the single-bit level-sensitive JK latch. Provides WIDTH independent edge-triggered JK flip-flops behind a valid/ready update port.
- Adds parallel load, a freeze state machine, and a saturating toggle-event counter.
- Sits between control-logic decoders and downstream status registers as a multi-channel set/reset/toggle store.

Parameters:
- WIDTH, 8: number of JK channels (≥1).
- CNT_W, 16: width of the toggle-event counter (≥2).
- RST_VAL, 0: WIDTH-bit reset value of Q.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  J/K update presented.
- in_ready  out  1  bank will accept an update this cycle.
- j  in  WIDTH  per-channel J.
- k  in  WIDTH  per-channel K.
- ld  in  1  synchronous parallel load strobe.
- ld_val  in  WIDTH  value written on ld.
- freeze  in  1  request to enter FROZEN.
- unfreeze  in  1  request to return to RUN.
- q  out  WIDTH  flip-flop state.
- qn  out  WIDTH  ~q, combinational.
- upd  out  1  one-cycle pulse: q changed on the previous edge.
- tog_cnt  out  CNT_W  saturating count of toggled bits.
- frozen  out  1  FSM is in FROZEN.

Behaviour:
- Reset (async assert, sync-safe deassert): q=RST_VAL, upd=0, tog_cnt=0, FSM=RUN, frozen=0.
- FSM states:
  - RUN: in_ready=1. freeze=1 moves to FROZEN at the next edge; the update accepted in that same cycle still applies.
  - FROZEN: in_ready=0, j/k ignored. unfreeze=1 moves to RUN at the next edge. freeze and unfreeze both high: stay in the current state.
- Accept: in_valid & in_ready at a rising edge. For each bit i, q[i] updates by {j,k}:
  - 00 hold
  - 01 clear
  - 10 set
  - 11 toggle
- Latency: q updates on the accepting edge; visible in the following cycle.
- ld priority: ld=1 loads q=ld_val in any state, overriding an accepted J/K update in the same cycle.
  - ld does not change the FSM state.
  - ld does not add to tog_cnt.
- upd: registered; 1 for exactly one cycle after any edge where q changed (J/K or ld), else 0.
- tog_cnt:
  - Each accepted J/K update adds popcount of the bits whose value changed, counting only bits with {j,k}=11. Set/clear transitions do not count.
  - The add is computed at CNT_W+1 bits and saturates at 2^CNT_W-1; it never wraps.
- Back-to-back accepts every cycle are legal; no bubbles in RUN.
- Idle or no-change edges: upd=0 and tog_cnt unchanged.
- Reset mid-operation: all state returns to reset values immediately; a pending accept is discarded.

Optional Feature:
- Macro: JK_REG_BANK_CLR_CNT_EN.
- Defined:
  - Adds input port cnt_clr (1 bit). cnt_clr=1 zeroes tog_cnt at the next edge, taking priority over that cycle's increment.
  - Adds output cnt_sat (1 bit), high while tog_cnt == all-ones.
- Undefined: neither port exists; tog_cnt clears only on reset.

Decomposition:
- Package jk_reg_bank_pkg holds:
  - enum type for the FSM states (RUN, FROZEN);
  - localparam encodings for the {j,k} commands (HOLD, CLR, SET, TGL);
  - a popcount function.
- One natural sub-module: jk_cell, a single JK bit with ld override. It outputs next-q and a toggled flag and is instantiated WIDTH times by generate.
- The FSM, handshake and counter live in the top.

Test Plan:
- Reset: WIDTH=8, RST_VAL=8'hA5 → q=A5, qn=5A, tog_cnt=0, in_ready=1, upd=0.
- JK commands: q=A5; j=F0, k=0F, valid=1 → q=F0, upd pulses once, tog_cnt=0. Then j=k=FF → q=0F, tog_cnt=8.
- Freeze: freeze with valid j=FF,k=FF in same cycle → toggle applied, frozen=1. Then j=k=FF held 3 cycles → q stable, in_ready=0. unfreeze → RUN one cycle later.
- ld priority: ld=1, ld_val=3C with j=k=FF valid → q=3C, tog_cnt unchanged, upd=1.
- Saturation: CNT_W=4, repeated j=k=FF → tog_cnt 8 then 15, held at 15. With JK_REG_BANK_CLR_CNT_EN: cnt_sat=1; cnt_clr together with a toggle → tog_cnt=0.
- Async reset mid-stream: rst_n low between edges during continuous accepts → q=RST_VAL and tog_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/jk_reg_bank_pkg.sv
// Shared types and helpers for the jk_reg_bank JK register bank.
package jk_reg_bank_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } state_e;

    // {j,k} command encodings
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Widest vector popcount accepts; callers zero-extend to this width.
    localparam int POP_MAX_W = 256;

    function automatic logic [31:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/jk_reg_bank_cell.sv
// One JK bit: computes next state from {j,k}, with parallel load taking priority.
module jk_cell
    import jk_reg_bank_pkg::*;
(
    input  logic q_i,
    input  logic j_i,
    input  logic k_i,
    input  logic en_i,
    input  logic ld_i,
    input  logic ld_val_i,
    output logic q_next_o,
    output logic tog_o
);

    // Next-state select; tog_o flags a counted toggle (never on a load)
    always_comb begin
        q_next_o = q_i;
        tog_o    = 1'b0;
        if (ld_i) begin
            q_next_o = ld_val_i;
        end else if (en_i) begin
            case ({j_i, k_i})
                JK_HOLD: q_next_o = q_i;
                JK_CLR:  q_next_o = 1'b0;
                JK_SET:  q_next_o = 1'b1;
                JK_TGL: begin
                    q_next_o = ~q_i;
                    tog_o    = 1'b1;
                end
                default: q_next_o = q_i;
            endcase
        end
    end

endmodule

// File: rtl/jk_reg_bank.sv
// Multi-channel edge-triggered JK register bank with valid/ready update port,
// parallel load, RUN/FROZEN state machine and saturating toggle counter.
// Optional feature macro: JK_REG_BANK_CLR_CNT_EN (adds cnt_clr / cnt_sat).
module jk_reg_bank
    import jk_reg_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 16,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             freeze,
    input  logic             unfreeze,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             upd,
    output logic [CNT_W-1:0] tog_cnt,
    output logic             frozen
`ifdef JK_REG_BANK_CLR_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic             cnt_sat
`endif
);

    // Arithmetic width for the counter add: at least CNT_W+1, and wide
    // enough to hold a raw popcount before it is clamped.
    localparam int             PW      = (CNT_W + 1 > 32) ? CNT_W + 1 : 32;
    localparam logic [PW-1:0]  CNT_MAX = PW'({CNT_W{1'b1}});

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              upd_q, upd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  tog;
    logic              accept;
    logic [PW-1:0]     pc_w, inc_w, sum_w;

    assign in_ready = (state_q == ST_RUN);
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .q_i      (q_q[i]),
            .j_i      (j[i]),
            .k_i      (k[i]),
            .en_i     (accept),
            .ld_i     (ld),
            .ld_val_i (ld_val[i]),
            .q_next_o (q_d[i]),
            .tog_o    (tog[i])
        );
    end

    // FSM next state: simultaneous freeze and unfreeze keep the current state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (freeze && !unfreeze) state_d = ST_FROZEN;
            ST_FROZEN: if (unfreeze && !freeze) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // Change pulse and saturating toggle count; increment is clamped first so the sum cannot overflow
    always_comb begin
        upd_d = (q_d != q_q);
        pc_w  = PW'(popcount(POP_MAX_W'(tog)));
        inc_w = (pc_w > CNT_MAX) ? CNT_MAX : pc_w;
        sum_w = PW'(cnt_q) + inc_w;
        cnt_d = (sum_w > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_w[CNT_W-1:0];
`ifdef JK_REG_BANK_CLR_CNT_EN
        if (cnt_clr) cnt_d = '0;
`endif
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            q_q     <= RST_VAL;
            upd_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            upd_q   <= upd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign upd     = upd_q;
    assign tog_cnt = cnt_q;
    assign frozen  = (state_q == ST_FROZEN);
`ifdef JK_REG_BANK_CLR_CNT_EN
    assign cnt_sat = &cnt_q;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed testbench for jk_reg_bank: a CNT_W=4 instance (saturation) and a
// CNT_W=16 instance (non-saturating count) share the same stimulus.
module tb_jk_reg_bank;

    localparam int         W   = 8;
    localparam logic [7:0] RV  = 8'hA5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, ld, freeze, unfreeze;
    logic [W-1:0] j, k, ld_val;

    logic         rdy_a, rdy_b, upd_a, upd_b, frz_a, frz_b;
    logic [W-1:0] q_a, qn_a, q_b, qn_b;
    logic [3:0]   cnt_a;
    logic [15:0]  cnt_b;
`ifdef JK_REG_BANK_CLR_CNT_EN
    logic         cnt_clr;
    logic         sat_a, sat_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jk_reg_bank #(.WIDTH(W), .CNT_W(4), .RST_VAL(RV)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
        .j(j), .k(k), .ld(ld), .ld_val(ld_val), .freeze(freeze),
        .unfreeze(unfreeze), .q(q_a), .qn(qn_a), .upd(upd_a),
        .tog_cnt(cnt_a), .frozen(frz_a)
`ifdef JK_REG_BANK_CLR_CNT_EN
        , .cnt_clr(cnt_clr), .cnt_sat(sat_a)
`endif
    );

    jk_reg_bank #(.WIDTH(W), .CNT_W(16), .RST_VAL(RV)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
        .j(j), .k(k), .ld(ld), .ld_val(ld_val), .freeze(freeze),
        .unfreeze(unfreeze), .q(q_b), .qn(qn_b), .upd(upd_b),
        .tog_cnt(cnt_b), .frozen(frz_b)
`ifdef JK_REG_BANK_CLR_CNT_EN
        , .cnt_clr(cnt_clr), .cnt_sat(sat_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] jj, input logic [W-1:0] kk);
        in_valid = v;
        j        = jj;
        k        = kk;
    endtask

    initial begin
        rst_n    = 1'b0;
        ld       = 1'b0;
        ld_val   = '0;
        freeze   = 1'b0;
        unfreeze = 1'b0;
        drive(1'b0, '0, '0);
`ifdef JK_REG_BANK_CLR_CNT_EN
        cnt_clr  = 1'b0;
`endif
        #12;
        check("rst_q",     32'(q_a),   32'hA5);
        check("rst_qn",    32'(qn_a),  32'h5A);
        check("rst_cnt",   32'(cnt_b), 32'd0);
        check("rst_ready", 32'(rdy_a), 32'd1);
        check("rst_upd",   32'(upd_a), 32'd0);
        check("rst_frz",   32'(frz_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // set upper nibble, clear lower: A5 -> F0, no toggles counted
        drive(1'b1, 8'hF0, 8'h0F);
        tick();
        check("setclr_q",   32'(q_a),   32'hF0);
        check("setclr_upd", 32'(upd_a), 32'd1);
        check("setclr_cnt", 32'(cnt_b), 32'd0);

        // toggle all: F0 -> 0F, eight toggles
        drive(1'b1, 8'hFF, 8'hFF);
        tick();
        check("tgl_q",     32'(q_b),   32'h0F);
        check("tgl_cnt_a", 32'(cnt_a), 32'd8);
        check("tgl_cnt_b", 32'(cnt_b), 32'd8);

        // idle edge: no pulse, count held
        drive(1'b0, 8'hFF, 8'hFF);
        tick();
        check("idle_upd", 32'(upd_a), 32'd0);
        check("idle_q",   32'(q_a),   32'h0F);
        check("idle_cnt", 32'(cnt_b), 32'd8);

        // freeze with a same-cycle toggle: toggle still lands, 8+8 saturates CNT_W=4
        freeze = 1'b1;
        drive(1'b1, 8'hFF, 8'hFF);
        tick();
        freeze = 1'b0;
        check("frz_q",     32'(q_a),   32'hF0);
        check("frz_state", 32'(frz_a), 32'd1);
        check("frz_ready", 32'(rdy_a), 32'd0);
        check("sat_cnt_a", 32'(cnt_a), 32'd15);
        check("frz_cnt_b", 32'(cnt_b), 32'd16);

        for (int i = 0; i < 3; i++) begin
            tick();
            check("frozen_q",     32'(q_b),   32'hF0);
            check("frozen_ready", 32'(rdy_b), 32'd0);
            check("frozen_upd",   32'(upd_b), 32'd0);
            check("frozen_cnt",   32'(cnt_b), 32'd16);
        end

        // unfreeze: back to RUN after one edge
        drive(1'b0, '0, '0);
        unfreeze = 1'b1;
        check("unfrz_pre", 32'(frz_a), 32'd1);
        tick();
        unfreeze = 1'b0;
        check("unfrz_state", 32'(frz_a), 32'd0);
        check("unfrz_ready", 32'(rdy_a), 32'd1);

        // load overrides a same-cycle toggle and does not count
        ld     = 1'b1;
        ld_val = 8'h3C;
        drive(1'b1, 8'hFF, 8'hFF);
        tick();
        ld = 1'b0;
        check("ld_q",   32'(q_b),   32'h3C);
        check("ld_upd", 32'(upd_b), 32'd1);
        check("ld_cnt", 32'(cnt_b), 32'd16);

        // back-to-back toggles every cycle; narrow counter held at 15
        tick();
        check("b2b1_q",     32'(q_a),   32'hC3);
        check("b2b1_cnt_b", 32'(cnt_b), 32'd24);
        check("b2b1_cnt_a", 32'(cnt_a), 32'd15);
        tick();
        check("b2b2_q",     32'(q_a),   32'h3C);
        check("b2b2_cnt_b", 32'(cnt_b), 32'd32);
        check("b2b2_cnt_a", 32'(cnt_a), 32'd15);
        check("b2b2_upd",   32'(upd_a), 32'd1);

`ifdef JK_REG_BANK_CLR_CNT_EN
        check("sat_a", 32'(sat_a), 32'd1);
        check("sat_b", 32'(sat_b), 32'd0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_q",     32'(q_a),   32'hC3);
        check("clr_cnt_a", 32'(cnt_a), 32'd0);
        check("clr_cnt_b", 32'(cnt_b), 32'd0);
        check("clr_sat_a", 32'(sat_a), 32'd0);
`endif

        // freeze and unfreeze together in RUN: stay in RUN; hold command is a no-change edge
        freeze   = 1'b1;
        unfreeze = 1'b1;
        drive(1'b1, 8'h00, 8'h00);
        tick();
        freeze   = 1'b0;
        unfreeze = 1'b0;
        check("both_state", 32'(frz_a), 32'd0);
        check("both_upd",   32'(upd_a), 32'd0);

        // async reset mid-stream, asserted between edges
        drive(1'b1, 8'hFF, 8'hFF);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q",     32'(q_a),   32'hA5);
        check("arst_cnt_b", 32'(cnt_b), 32'd0);
        check("arst_upd",   32'(upd_b), 32'd0);
        tick();
        check("arst_hold_q", 32'(q_b), 32'hA5);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, '0);
        tick();
        check("post_rst_q",   32'(q_a),   32'hA5);
        check("post_rst_cnt", 32'(cnt_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
